// File: rtl/uart_start_bit.sv
// UART receiver front stage: synchronises the serial line, hunts for a start-bit edge and
// confirms it at mid-bit. Optional 3-sample majority vote enabled by UART_START_GLITCH_FILTER_EN.
module uart_start_bit #(
   parameter int OSR         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_rx,
   input  logic i_arm,
   output logic o_start,
   output logic o_busy,
   output logic o_false_start
);

   localparam int CW = $clog2(OSR) + 1;
`ifdef UART_START_GLITCH_FILTER_EN
   localparam logic [CW-1:0] DECIDE_CNT = CW'(OSR / 2 + 1);
`else
   localparam logic [CW-1:0] DECIDE_CNT = CW'(OSR / 2);
`endif

   typedef enum logic [1:0] {
      WAIT_IDLE,
      HUNT,
      VERIFY
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [SYNC_STAGES-1:0] sync_q;
   logic rx_s;
   logic sample;
   logic start_q, start_d;
   logic false_q, false_d;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Synchroniser runs on every clock; idle-high reset avoids a phantom edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      end
   end

`ifdef UART_START_GLITCH_FILTER_EN
   // Last two VERIFY-tick samples; at the decision tick they hold mid-1 and mid.
   logic [1:0] hist_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hist_q <= 2'b11;
      end else if (i_en && state_q == VERIFY) begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= WAIT_IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
         false_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         false_q <= false_d;
      end
   end

   // cnt_inc is the index of the current tick counted from the edge tick (tick 0).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      false_d = 1'b0;
      cnt_inc = cnt_q + CW'(1);
      if (i_en) begin
         if (!i_arm) begin
            state_d = WAIT_IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               WAIT_IDLE: begin
                  if (rx_s) begin
                     state_d = HUNT;
                  end
               end
               HUNT: begin
                  if (!rx_s) begin
                     state_d = VERIFY;
                     cnt_d   = '0;
                  end
               end
               VERIFY: begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DECIDE_CNT) begin
                     state_d = WAIT_IDLE;
                     cnt_d   = '0;
                     if (sample) begin
                        false_d = 1'b1;
                     end else begin
                        start_d = 1'b1;
                     end
                  end
               end
               default: begin
                  state_d = WAIT_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   assign o_start       = start_q;
   assign o_false_start = false_q;
   assign o_busy        = (state_q == VERIFY);

endmodule
